// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: one WIDTH-bit word per handshake, least-significant word
// first, with the ripple adder's carry-out fed back as the next word's carry-in.

module gen_FA #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   logic [WIDTH:0] c;

   assign c[0] = c_in;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign c_out = c[WIDTH];
endmodule

module multiword_add_seq #(
   parameter  int WIDTH = 5,
   parameter  int WORDS = 4,
   localparam int IW    = (WORDS > 2) ? $clog2(WORDS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             c_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             sum_valid,
   output logic [IW-1:0]    word_idx,
   output logic             c_out,
   output logic             done,
   output logic             busy,
   output logic [1:0]       state_dbg
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   state_t           state_q;
   logic             carry_q;
   logic [IW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             sum_valid_q;
   logic [IW-1:0]    word_idx_q;
   logic             c_out_q;
   logic             done_q;

   logic [WIDTH-1:0] fa_sum;
   logic             fa_cout;

   gen_FA #(.WIDTH(WIDTH)) u_fa (
      .a     (a),
      .b     (b),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   // Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready
   // is high for the whole of RUN and never depends on in_valid. Outputs have no ready.
   assign in_ready  = (state_q == S_RUN);
   assign busy      = (state_q != S_IDLE);
   assign sum       = sum_q;
   assign sum_valid = sum_valid_q;
   assign word_idx  = word_idx_q;
   assign c_out     = c_out_q;
   assign done      = done_q;
   assign state_dbg = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         word_idx_q  <= '0;
         c_out_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         sum_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  carry_q <= c_in;
                  cnt_q   <= '0;
                  c_out_q <= 1'b0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (in_valid) begin
                  carry_q     <= fa_cout;
                  sum_q       <= fa_sum;
                  word_idx_q  <= cnt_q;
                  sum_valid_q <= 1'b1;
                  // The counter stops at the last index so it never leaves 0..WORDS-1.
                  if (cnt_q == LAST_IDX) begin
                     c_out_q <= fa_cout;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq (WIDTH=5, WORDS=4): directed vector table, protocol and
// reset-abort sequences, and random operations checked against a 21-bit reference sum.

module tb_multiword_add_seq;
   localparam int WIDTH = 5;
   localparam int WORDS = 4;
   localparam int IW    = 2;
   localparam int W     = IW + WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             c_in;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             sum_valid;
   logic [IW-1:0]    word_idx;
   logic             c_out;
   logic             done;
   logic             busy;
   logic [1:0]       state_dbg;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [W-1:0] exp_q[$];
   logic         exp_c_q[$];

   typedef struct {
      logic        ci;
      logic [19:0] av;
      logic [19:0] bv;
      int          gap_mode;
      logic [19:0] exp_s;
      logic        exp_c;
   } vec_t;

   multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .c_in      (c_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sum       (sum),
      .sum_valid (sum_valid),
      .word_idx  (word_idx),
      .c_out     (c_out),
      .done      (done),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Scoreboard: pops one expected word per sum_valid, one expected carry per done.
   always @(negedge clk) begin
      if (!rst) begin
         if (sum_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_sum_valid", 32'(word_idx), 32'hFFFF);
            end else begin
               chk("sum_word", 32'({word_idx, sum}), 32'(exp_q.pop_front()));
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_align", 32'({sum_valid, word_idx}), 32'({1'b1, 2'd3}));
            if (exp_c_q.size() == 0) chk("unexpected_done", 32'(c_out), 32'hFFFF);
            else chk("c_out", 32'(c_out), 32'(exp_c_q.pop_front()));
         end
      end
   end

   task automatic run_op(input logic ci, input logic [19:0] av, input logic [19:0] bv,
                         input int gap_mode, input bit hold_start,
                         input logic [19:0] es, input logic ec);
      int d0;
      int ngap;
      for (int k = 0; k < WORDS; k++) exp_q.push_back({IW'(k), es[k*WIDTH +: WIDTH]});
      exp_c_q.push_back(ec);
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; c_in = ci; in_valid = 1'b0;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      c_in = 1'($urandom_range(0, 1));
      chk("busy_run", 32'(busy), 32'd1);
      for (int k = 0; k < WORDS; k++) begin
         ngap = (gap_mode == 1) ? ((k == 0) ? 0 : 2) :
                (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         repeat (ngap) begin
            in_valid = 1'b0; a = 5'($urandom); b = 5'($urandom);
            @(posedge clk); #1;
         end
         chk("in_ready_run", 32'(in_ready), 32'd1);
         in_valid = 1'b1; a = av[k*WIDTH +: WIDTH]; b = bv[k*WIDTH +: WIDTH];
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      chk("in_ready_done", 32'({in_ready, busy}), 32'({1'b0, 1'b1}));
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_idle", 32'({busy, in_ready}), 32'd0);
      chk("done_once", 32'(done_cnt - d0), 32'd1);
      chk("c_out_hold", 32'(c_out), 32'(ec));
   endtask

   vec_t vecs[7];

   initial begin
      logic [19:0] ra, rb;
      logic        rc;
      logic [20:0] full;
      int          d0;

      vecs[0] = '{1'b0, {5'd0, 5'd31, 5'd0, 5'd31}, {5'd0, 5'd0, 5'd0, 5'd1}, 0,
                  {5'd0, 5'd31, 5'd1, 5'd0}, 1'b0};
      vecs[1] = '{1'b1, {4{5'd31}}, 20'd0, 0, 20'd0, 1'b1};
      vecs[2] = '{1'b0, {5'd0, 5'd31, 5'd0, 5'd31}, {5'd0, 5'd0, 5'd0, 5'd1}, 1,
                  {5'd0, 5'd31, 5'd1, 5'd0}, 1'b0};
      vecs[3] = '{1'b1, {4{5'd31}}, {4{5'd31}}, 0, {4{5'd31}}, 1'b1};
      vecs[4] = '{1'b0, {4{5'd5}}, {4{5'd6}}, 0, {4{5'd11}}, 1'b0};
      vecs[5] = '{1'b0, 20'd0, 20'd0, 0, 20'd0, 1'b0};
      vecs[6] = '{1'b1, 20'd0, 20'd0, 1, {5'd0, 5'd0, 5'd0, 5'd1}, 1'b0};

      rst = 1'b1; start = 1'b0; c_in = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      #12;
      chk("reset_outputs", 32'({sum, sum_valid, word_idx, c_out, done, busy, in_ready}), 32'd0);
      chk("reset_state", 32'(state_dbg), 32'd0);
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].ci, vecs[i].av, vecs[i].bv, vecs[i].gap_mode, 1'b0,
                vecs[i].exp_s, vecs[i].exp_c);

      // Operands and in_valid driven while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a = 5'($urandom); b = 5'($urandom);
         chk("in_ready_idle", 32'({in_ready, busy}), 32'd0);
      end
      // start held high through RUN and DONE.
      run_op(1'b1, {4{5'd31}}, 20'd0, 0, 1'b1, 20'd0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("no_restart", 32'(busy), 32'd0);

      // Reset abort after two accepted words.
      exp_q.push_back({2'd0, 5'd0});
      exp_q.push_back({2'd1, 5'd1});
      d0 = done_cnt;
      @(posedge clk); #1; start = 1'b1; c_in = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      in_valid = 1'b1; a = 5'd31; b = 5'd1;
      @(posedge clk); #1; a = 5'd0; b = 5'd0;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #2; rst = 1'b1;
      #1;
      chk("abort_outputs", 32'({sum, sum_valid, word_idx, c_out, done, busy, in_ready}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      chk("abort_queue", 32'(exp_q.size()), 32'd0);
      run_op(vecs[0].ci, vecs[0].av, vecs[0].bv, 0, 1'b0, vecs[0].exp_s, vecs[0].exp_c);

      for (int n = 0; n < 500; n++) begin
         ra = 20'($urandom); rb = 20'($urandom); rc = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + 21'(rc);
         run_op(rc, ra, rb, 2, 1'b0, full[19:0], full[20]);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size() + exp_c_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
